// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int INS_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        BYTE,
        WRITE,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: MSB-first 8-to-32 shift register with a 2-bit byte index.
// The completed word is captured separately so it stays stable while the next word shifts in.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [7:0]       in_byte,
    output logic [INS_W-1:0] word,
    output logic             word_complete
);

    logic [1:0]       r_idx;
    logic [INS_W-9:0] r_sh;
    logic [INS_W-1:0] r_word;

    assign word_complete = shift_en && r_idx == 2'(BYTES_PER_WORD - 1);
    assign word          = r_word;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx  <= '0;
            r_sh   <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_idx <= '0;
            r_sh  <= '0;
        end else if (shift_en) begin
            r_sh  <= {r_sh[INS_W-17:0], in_byte};
            r_idx <= r_idx + 2'd1;
            if (word_complete)
                r_word <= {r_sh, in_byte};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader driving the IF instruction-memory write port (W_Ins/WE).
// Define IMEM_LOADER_CHECKSUM_EN to append and verify a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [INS_W-1:0] W_Ins,
    output logic             WE,
    output logic             hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t           r_state, w_next;
    logic             r_in_ready, r_we, r_hold, r_done, r_err;
    logic [CNT_W-1:0] r_cnt, r_ww, w_hdr_cnt;
    logic             w_xfer, w_start, w_shift, w_complete, w_ck_bad;
    logic             w_in_ready, w_we, w_hold, w_done;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_start   = start && (r_state == IDLE || r_state == DONE);
    assign w_shift   = w_xfer && r_state == BYTE;
    assign w_hdr_cnt = r_cnt | CNT_W'(in_data);

    byte_word_assembler u_asm (
        .CLK           (CLK),
        .RST           (RST),
        .clear         (w_start),
        .shift_en      (w_shift),
        .in_byte       (in_data),
        .word          (W_Ins),
        .word_complete (w_complete)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_xor <= '0;
        else if (w_start)
            r_xor <= '0;
        else if (w_xfer && r_state != CHK)
            r_xor <= r_xor ^ in_data;
    end

    assign w_ck_bad = w_xfer && r_state == CHK && in_data != r_xor;
`else
    assign w_ck_bad = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_in_ready;
            r_we       <= w_we;
            r_hold     <= w_hold;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = start ? HDR0 : IDLE;
            HDR0:  w_next = w_xfer ? HDR1 : HDR0;
            HDR1:
                if (w_xfer)
                    w_next = w_hdr_cnt == '0 ? END_ST :
                             w_hdr_cnt > CNT_W'(MAX_WORDS) ? DONE : BYTE;
            BYTE:  w_next = w_complete ? WRITE : BYTE;
            WRITE: w_next = r_ww + CNT_W'(1) == r_cnt ? END_ST : BYTE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:   w_next = w_xfer ? DONE : CHK;
`endif
            DONE:  w_next = start ? HDR0 : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        w_in_ready = w_next inside {HDR0, HDR1, BYTE, CHK};
        w_we       = w_next == WRITE;
        w_hold     = !(w_next inside {IDLE, DONE});
        w_done     = w_next == DONE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_ww  <= '0;
            r_err <= 1'b0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_ww  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_xfer && r_state == HDR0)
                r_cnt <= CNT_W'(in_data) << (8 * (HDR_BYTES - 1));
            if (w_xfer && r_state == HDR1) begin
                r_cnt <= w_hdr_cnt;
                if (w_hdr_cnt > CNT_W'(MAX_WORDS))
                    r_err <= 1'b1;
            end
            if (r_state == WRITE)
                r_ww <= r_ww + CNT_W'(1);
            if (w_ck_bad)
                r_err <= 1'b1;
        end
    end

    assign in_ready      = r_in_ready;
    assign WE            = r_we;
    assign hold          = r_hold;
    assign done          = r_done;
    assign err           = r_err;
    assign words_written = r_ww;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized checks of imem_loader against a stream model.
module tb_imem_loader;

    localparam int MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        CLK = 1'b0, RST = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, WE, hold, done, err;
    logic [31:0] W_Ins;
    logic [15:0] words_written;

    int          checks = 0, failures = 0;
    logic [31:0] got_q[$];

    typedef struct {
        logic [15:0] cnt;
        int          mode;
        bit          preset;
        bit          bad;
        bit          exp_err;
        int          exp_ww;
    } vec_t;

    vec_t tbl[9];

    always #5 CLK = ~CLK;

    imem_loader dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .W_Ins         (W_Ins),
        .WE            (WE),
        .hold          (hold),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK)
        if (!RST && WE) begin
            got_q.push_back(W_Ins);
            chk("in_ready_low_in_write", 32'(in_ready), 32'd0);
        end

    function automatic int gap_of(input int mode);
        return mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 3));
    endfunction

    function automatic void model(input logic [15:0] cnt, input bit bad, output bit e, output int ww);
        e  = cnt > MAXW || bad;
        ww = cnt > MAXW ? 0 : int'(cnt);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            ok = in_ready;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] cnt, input int mode, input bit preset,
                            input bit bad, input bit exp_err, input int exp_ww);
        logic [7:0]  bytes[$];
        logic [31:0] exp_w[$];
        logic [31:0] w;
        logic [7:0]  ck;
        int          nw;
        nw = cnt > MAXW ? 0 : int'(cnt);
        bytes.push_back(cnt[15:8]);
        bytes.push_back(cnt[7:0]);
        for (int i = 0; i < nw; i++) begin
            w = preset ? (i == 0 ? 32'h20080005 : 32'hAC080004) : $urandom;
            exp_w.push_back(w);
            for (int k = 3; k >= 0; k--) bytes.push_back(8'(w >> (8 * k)));
        end
        ck = '0;
        foreach (bytes[i]) ck ^= bytes[i];
        if (CK && cnt <= MAXW) bytes.push_back(ck ^ {7'd0, bad});
        got_q.delete();
        pulse_start();
        chk("hold_after_start", 32'(hold), 32'd1);
        chk("ready_in_hdr0", 32'(in_ready), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        foreach (bytes[i]) send_byte(bytes[i], gap_of(mode));
        for (int t = 0; t < 64 && !done; t++) begin @(posedge CLK); #1; end
        chk("done", 32'(done), 32'd1);
        chk("err", 32'(err), 32'(exp_err));
        chk("words_written", 32'(words_written), 32'(exp_ww));
        chk("hold_in_done", 32'(hold), 32'd0);
        chk("we_count", 32'(got_q.size()), 32'(exp_w.size()));
        foreach (exp_w[i]) chk("w_ins", i < got_q.size() ? got_q[i] : 32'hxxxxxxxx, exp_w[i]);
        if (cnt > MAXW) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            repeat (4) begin
                @(posedge CLK); #1;
                chk("reject_not_consumed", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            chk("reject_no_we", 32'(got_q.size()), 32'd0);
        end
    endtask

    initial begin
        bit          e, bad;
        int          ww;
        logic [15:0] cnt;
        tbl[0] = '{16'd2,      0, 1'b1, 1'b0, 1'b0, 2};
        tbl[1] = '{16'd2,      1, 1'b1, 1'b0, 1'b0, 2};
        tbl[2] = '{16'd257,    0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{16'd0,      0, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{16'd0,      0, 1'b0, CK,   CK,   0};
        tbl[5] = '{16'd1,      2, 1'b0, 1'b0, 1'b0, 1};
        tbl[6] = '{16'd256,    0, 1'b0, 1'b0, 1'b0, 256};
        tbl[7] = '{16'hFFFF,   2, 1'b0, 1'b0, 1'b1, 0};
        tbl[8] = '{16'd3,      2, 1'b0, CK,   CK,   3};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_w_ins", W_Ins, 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        RST = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("idle_not_ready", 32'(in_ready), 32'd0);

        foreach (tbl[i])
            run_load(tbl[i].cnt, tbl[i].mode, tbl[i].preset, tbl[i].bad, tbl[i].exp_err, tbl[i].exp_ww);

        got_q.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        #2 RST = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_we", 32'(WE), 32'd0);
        chk("midrst_w_ins", W_Ins, 32'd0);
        chk("midrst_hold", 32'(hold), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_words", 32'(words_written), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("midrst_no_we", 32'(got_q.size()), 32'd0);
        chk("midrst_idle", 32'(in_ready), 32'd0);
        run_load(16'd2, 0, 1'b1, 1'b0, 1'b0, 2);

        for (int r = 0; r < 12; r++) begin
            cnt = $urandom_range(0, 9) == 0 ? 16'(257 + $urandom_range(0, 1000)) : 16'($urandom_range(0, 12));
            bad = CK && $urandom_range(0, 1) == 1;
            model(cnt, bad, e, ww);
            run_load(cnt, int'($urandom_range(0, 2)), 1'b0, bad, e, ww);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
